// File: rtl/spi_mosi_if.sv
// SPI mode-0 slave receive front-end, MSB first.
// Oversamples the SPI pins in the sys_clk domain and captures one WIDTH-bit word
// per chip-select frame into a parallel buffer with a level valid flag.
module spi_mosi_if #(
    parameter int WIDTH = 16
) (
    input  logic             sys_clk,
    input  logic             sys_reset_n,
    input  logic             spi_clk,
    input  logic             spi_mosi,
    input  logic             spi_cs_n,
    output logic             spi_miso,
    output logic [WIDTH-1:0] mosi_buffer,
    output logic             mosi_buffer_valid
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    // [0],[1] form the 2-flop synchronizer, [2] is the edge-detect history stage
    logic [2:0]       sclk_q;
    logic [2:0]       cs_q;
    logic [1:0]       mosi_q;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             sclk_rise, cs_fall, cs_rise;

    // Receive-only: MISO is never driven.
    assign spi_miso = 1'b0;

    // Synchronize the pins; CS resets to its idle (high) level.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            sclk_q <= 3'b000;
            cs_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_clk};
            cs_q   <= {cs_q[1:0], spi_cs_n};
            mosi_q <= {mosi_q[0], spi_mosi};
        end
    end

    // MOSI has the same sync depth as SCLK, so mosi_q[1] is aligned with sclk_rise.
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];

    // Next shift/count values; the completion check uses these so a bit that
    // lands in the same cycle as cs_rise is counted before the check.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (state_q == SHIFT && sclk_rise) begin
            shreg_d = {shreg_q[WIDTH-2:0], mosi_q[1]};
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
        end
    end

    // Frame FSM: arm on cs_fall, shift while selected, publish only exact-length frames.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q           <= IDLE;
            shreg_q           <= '0;
            cnt_q             <= '0;
            mosi_buffer       <= '0;
            mosi_buffer_valid <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        shreg_q           <= '0;
                        cnt_q             <= '0;
                        mosi_buffer_valid <= 1'b0;
                        state_q           <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg_q <= shreg_d;
                    cnt_q   <= cnt_d;
                    if (cs_rise) begin
                        state_q <= IDLE;
                        if (cnt_d == CNT_FULL) begin
                            mosi_buffer       <= shreg_d;
                            mosi_buffer_valid <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mosi_if.sv
// Self-checking bench for spi_mosi_if: directed frames from the test plan plus
// randomized frames, checked against a frame-level model of the receiver.
module tb_spi_mosi_if;

    localparam int WIDTH = 16;

    logic             sys_clk = 1'b0;
    logic             sys_reset_n = 1'b0;
    logic             spi_clk = 1'b0;
    logic             spi_mosi = 1'b0;
    logic             spi_cs_n = 1'b1;
    logic             spi_miso;
    logic [WIDTH-1:0] mosi_buffer;
    logic             mosi_buffer_valid;

    int errors = 0;
    int checks = 0;

    // Frame-level model: what the buffer and flag should show.
    logic [WIDTH-1:0] m_buf = '0;
    logic             m_vld = 1'b0;

    int half = 100;  // SPI half-period in sys_clk cycles (100 -> 500 kHz)

    spi_mosi_if #(.WIDTH(WIDTH)) dut (
        .sys_clk           (sys_clk),
        .sys_reset_n       (sys_reset_n),
        .spi_clk           (spi_clk),
        .spi_mosi          (spi_mosi),
        .spi_cs_n          (spi_cs_n),
        .spi_miso          (spi_miso),
        .mosi_buffer       (mosi_buffer),
        .mosi_buffer_valid (mosi_buffer_valid)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".vld"}, {31'd0, mosi_buffer_valid}, {31'd0, m_vld});
        chk({tag, ".buf"}, {16'd0, mosi_buffer}, {16'd0, m_buf});
        chk({tag, ".miso"}, {31'd0, spi_miso}, 32'd0);
    endtask

    // Select the slave; the model drops valid on the chip-select fall.
    task automatic start_frame(input string tag);
        spi_cs_n = 1'b0;
        m_vld = 1'b0;
        wait_cyc(half);
        chk_outputs({tag, ".infrm"});
    endtask

    // Mode 0: data set up while SCLK is low, sampled on the rising edge.
    task automatic send_bits(input logic [31:0] data, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = data[i];
            wait_cyc(half);
            spi_clk = 1'b1;
            wait_cyc(half);
            spi_clk = 1'b0;
        end
    endtask

    task automatic end_frame(input string tag, input logic [31:0] data, input int nbits,
                             input bit counted);
        wait_cyc(half);
        spi_cs_n = 1'b1;
        if (counted && nbits == WIDTH) begin
            m_buf = data[WIDTH-1:0];
            m_vld = 1'b1;
        end else begin
            m_vld = 1'b0;
        end
        wait_cyc(8);
        chk_outputs({tag, ".done"});
        spi_mosi = 1'b0;
        wait_cyc(half);
    endtask

    task automatic frame(input string tag, input logic [31:0] data, input int nbits);
        start_frame(tag);
        send_bits(data, nbits);
        end_frame(tag, data, nbits, 1'b1);
    endtask

    initial begin
        // Reset state
        wait_cyc(3);
        chk_outputs("reset");
        sys_reset_n = 1'b1;
        wait_cyc(5);
        chk_outputs("post_reset");

        // Nominal and back-to-back frames
        frame("dead", 32'hDEAD, 16);
        frame("b2b_1234", 32'h1234, 16);

        // Short and long frames after a good word
        frame("a5a5", 32'hA5A5, 16);
        frame("short15", 32'h7FFF, 15);
        frame("a5a5_b", 32'hA5A5, 16);
        frame("long17", 32'h1FFFF, 17);

        // Idle clocking with CS high leaves no residue
        for (int i = 0; i < 20; i++) begin
            spi_mosi = i[0];
            wait_cyc(half); spi_clk = 1'b1;
            wait_cyc(half); spi_clk = 1'b0;
        end
        spi_mosi = 1'b0;
        chk_outputs("idle_clk");
        frame("one", 32'h0001, 16);

        // Reset mid-frame
        start_frame("rstmid");
        send_bits(32'hBE, 8);
        sys_reset_n = 1'b0;
        m_buf = '0;
        m_vld = 1'b0;
        #1;
        chk_outputs("async_rst");
        wait_cyc(3);
        sys_reset_n = 1'b1;
        send_bits(32'hEF, 8);
        end_frame("rst_rest", 32'hEF, 8, 1'b0);
        frame("beef", 32'hBEEF, 16);

        // Randomized frames at a faster SPI clock
        half = 6;
        for (int k = 0; k < 40; k++) begin
            int r;
            int nb;
            logic [31:0] d;
            r = $urandom_range(0, 9);
            nb = (r < 6) ? WIDTH : (r == 6) ? WIDTH - 1 : (r == 7) ? WIDTH + 1 :
                 int'($urandom_range(0, WIDTH + 3));
            d = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                int ic;
                ic = $urandom_range(1, 5);
                for (int j = 0; j < ic; j++) begin
                    spi_mosi = $urandom_range(0, 1);
                    wait_cyc(half); spi_clk = 1'b1;
                    wait_cyc(half); spi_clk = 1'b0;
                end
                spi_mosi = 1'b0;
            end
            frame($sformatf("rnd%0d_n%0d", k, nb), d, nb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
